// File: rtl/mem_writeback_stage.sv
// Writeback stage after the synchronous data memory: aligns loads with their registered
// read data, muxes FU/memory results onto the register-file write port, counts retirements.
// Optional LOAD_INTERLOCK_EN exposes the pending-load destination for load-use hazard detection.
module mem_writeback_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_fu_result,
    input  logic                  in_md,
    input  logic                  in_rw,
    input  logic [REG_ADDR_W-1:0] in_da,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  flush,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data,
    output logic [CNT_W-1:0]      retired
`ifdef LOAD_INTERLOCK_EN
    ,
    output logic                  load_pending,
    output logic [REG_ADDR_W-1:0] load_da
`endif
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic                    pend_rw_q, pend_rw_d;
    logic [REG_ADDR_W-1:0]   pend_da_q, pend_da_d;
    logic                    rf_we_d;
    logic [REG_ADDR_W-1:0]   rf_addr_d;
    logic [DATA_W-1:0]       rf_data_d;
    logic [CNT_W-1:0]        retired_q, retired_d;
    logic                    accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready & ~flush;
    assign retired  = retired_q;

`ifdef LOAD_INTERLOCK_EN
    assign load_pending = (state_q == LOAD_WAIT);
    assign load_da      = (state_q == LOAD_WAIT) ? pend_da_q : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pend_rw_q <= 1'b0;
            pend_da_q <= '0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_rw_q <= pend_rw_d;
            pend_da_q <= pend_da_d;
            rf_we     <= rf_we_d;
            rf_addr   <= rf_addr_d;
            rf_data   <= rf_data_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_rw_d = pend_rw_q;
        pend_da_d = pend_da_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr;
        rf_data_d = rf_data;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_md) begin
                        rf_we_d   = in_rw;
                        rf_addr_d = in_da;
                        rf_data_d = in_fu_result;
                        retired_d = retired_q + CNT_ONE;
                    end else begin
                        // Memory data arrives next cycle; hold the command until then.
                        pend_rw_d = in_rw;
                        pend_da_d = in_da;
                        state_d   = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                state_d   = IDLE;
                pend_rw_d = 1'b0;
                pend_da_d = '0;
                if (!flush) begin
                    rf_we_d   = pend_rw_q;
                    rf_addr_d = pend_da_q;
                    rf_data_d = mem_data;
                    retired_d = retired_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed self-checking bench for mem_writeback_stage: reset, ALU stream, loads,
// load/ALU ordering, flush, rw=0, counter wrap and reset during a pending load.
module tb_mem_writeback_stage;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_fu_result;
    logic                  in_md;
    logic                  in_rw;
    logic [REG_ADDR_W-1:0] in_da;
    logic [DATA_W-1:0]     mem_data;
    logic                  flush;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0]     rf_data;
    logic [CNT_W-1:0]      retired;
`ifdef LOAD_INTERLOCK_EN
    logic                  load_pending;
    logic [REG_ADDR_W-1:0] load_da;
`endif

    int unsigned n_total;
    int unsigned n_pass;

    mem_writeback_stage #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fu_result(in_fu_result),
        .in_md       (in_md),
        .in_rw       (in_rw),
        .in_da       (in_da),
        .mem_data    (mem_data),
        .flush       (flush),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .retired     (retired)
`ifdef LOAD_INTERLOCK_EN
        ,
        .load_pending(load_pending),
        .load_da     (load_da)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_total++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [REG_ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] cnt);
        check({tag, ".we"},      64'(rf_we),   64'(we));
        check({tag, ".addr"},    64'(rf_addr), 64'(addr));
        check({tag, ".data"},    64'(rf_data), 64'(data));
        check({tag, ".retired"}, 64'(retired), 64'(cnt));
    endtask

    task automatic drive(input logic v, input logic md, input logic rw,
                         input logic [REG_ADDR_W-1:0] da, input logic [DATA_W-1:0] fu);
        in_valid     = v;
        in_md        = md;
        in_rw        = rw;
        in_da        = da;
        in_fu_result = fu;
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        mem_data = 32'h0;
        drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h99);

        // Reset held two cycles with a valid command present
        step();
        check_wr("rst0", 1'b0, 5'd0, 32'h0, 32'd0);
        step();
        check_wr("rst1", 1'b0, 5'd0, 32'h0, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
`ifdef LOAD_INTERLOCK_EN
        check("rst.load_pending", 64'(load_pending), 64'd0);
`endif

        // ALU stream
        drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h11);
        step();
        check_wr("alu0", 1'b1, 5'd3, 32'h11, 32'd1);
        check("alu0.in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h22);
        step();
        check_wr("alu1", 1'b1, 5'd4, 32'h22, 32'd2);
        drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h33);
        step();
        check_wr("alu2", 1'b1, 5'd5, 32'h33, 32'd3);
        check("alu2.in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        step();
        check_wr("alu_idle", 1'b0, 5'd5, 32'h33, 32'd3);

        // Single load: FU result and early mem_data must be ignored
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h55);
        mem_data = 32'h12345678;
        step();
        check_wr("ld_acc", 1'b0, 5'd5, 32'h33, 32'd3);
        check("ld_acc.in_ready", 64'(in_ready), 64'd0);
`ifdef LOAD_INTERLOCK_EN
        check("ld_acc.load_pending", 64'(load_pending), 64'd1);
        check("ld_acc.load_da", 64'(load_da), 64'd7);
`endif
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        mem_data = 32'hDEADBEEF;
        step();
        check_wr("ld_wr", 1'b1, 5'd7, 32'hDEADBEEF, 32'd4);
        check("ld_wr.in_ready", 64'(in_ready), 64'd1);
`ifdef LOAD_INTERLOCK_EN
        check("ld_wr.load_pending", 64'(load_pending), 64'd0);
        check("ld_wr.load_da", 64'(load_da), 64'd0);
`endif

        // Load then ALU held during LOAD_WAIT: ALU must wait, writes in order
        drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h0);
        step();
        check("la_acc.in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h77);
        mem_data = 32'hCAFEF00D;
        step();
        check_wr("la_ld", 1'b1, 5'd8, 32'hCAFEF00D, 32'd5);
        check("la_ld.in_ready", 64'(in_ready), 64'd1);
        step();
        check_wr("la_alu", 1'b1, 5'd9, 32'h77, 32'd6);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        step();
        check_wr("la_idle", 1'b0, 5'd9, 32'h77, 32'd6);

        // Flush during LOAD_WAIT
        drive(1'b1, 1'b1, 1'b1, 5'd10, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        flush    = 1'b1;
        mem_data = 32'h00000BAD;
        step();
        check_wr("fl_ld", 1'b0, 5'd9, 32'h77, 32'd6);
        check("fl_ld.in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0;
        step();
        check_wr("fl_ld_after", 1'b0, 5'd9, 32'h77, 32'd6);

        // Flush with an ALU command in IDLE
        drive(1'b1, 1'b0, 1'b1, 5'd11, 32'hEE);
        flush = 1'b1;
        step();
        check_wr("fl_alu", 1'b0, 5'd9, 32'h77, 32'd6);
        check("fl_alu.in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0;

        // rw=0 retires and updates address/data but no write strobe
        drive(1'b1, 1'b0, 1'b0, 5'd12, 32'h44);
        step();
        check_wr("rw0", 1'b0, 5'd12, 32'h44, 32'd7);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);

        // Counter wrap
        @(negedge clk);
        force dut.retired_q = '1;
        #1;
        release dut.retired_q;
        check("wrap.pre", 64'(retired), 64'hFFFF_FFFF);
        drive(1'b1, 1'b0, 1'b1, 5'd13, 32'h5A);
        step();
        check_wr("wrap", 1'b1, 5'd13, 32'h5A, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);

        // Reset during LOAD_WAIT drops the pending load
        drive(1'b1, 1'b1, 1'b1, 5'd14, 32'h0);
        step();
        check("rl_acc.in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
        rst_n    = 1'b0;
        mem_data = 32'h0000FEED;
        step();
        check_wr("rl_rst", 1'b0, 5'd0, 32'h0, 32'd0);
`ifdef LOAD_INTERLOCK_EN
        check("rl_rst.load_pending", 64'(load_pending), 64'd0);
        check("rl_rst.load_da", 64'(load_da), 64'd0);
`endif
        rst_n = 1'b1;
        step();
        check_wr("rl_after", 1'b0, 5'd0, 32'h0, 32'd0);
        check("rl_after.in_ready", 64'(in_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
